// File: rtl/spram_dma_pkg.sv
// Shared definitions for the spram_dma block-copy initiator.
// State encodings and the counter-width helper used by the top.
package spram_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Counters need one extra bit so a full 2^aw copy can be counted.
    function automatic int len_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/spram_dma.sv
// Block-copy initiator between two single-port RAMs: one read and one write per cycle,
// with the write stage running one cycle behind the read stage.
module spram_dma
    import spram_dma_pkg::*;
#(
    parameter int aw = 10,
    parameter int dw = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          hold,
    input  logic [aw-1:0] src_base,
    input  logic [aw-1:0] dst_base,
    input  logic [aw:0]   len,
    output logic          busy,
    output logic          done,
    output logic          src_ce,
    output logic          src_oe,
    output logic [aw-1:0] src_addr,
    input  logic [dw-1:0] src_dout,
    output logic          dst_ce,
    output logic          dst_we,
    output logic [aw-1:0] dst_addr,
    output logic [dw-1:0] dst_din
);

    localparam int LEN_W = len_width(aw);

    state_t           state, state_next;
    logic [aw-1:0]    src_base_q, dst_base_q;
    logic [LEN_W-1:0] len_q, rd_cnt, wr_cnt;
    logic             pending;
    logic             rd_fire, wr_fire, load, done_next;
    logic             last_rd, last_wr;

    assign last_rd = (rd_cnt + LEN_W'(1)) == len_q;
    assign last_wr = (wr_cnt + LEN_W'(1)) == len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Abort and reset suppress every RAM access in the cycle they are seen.
    always_comb begin
        state_next = state;
        rd_fire    = 1'b0;
        wr_fire    = 1'b0;
        load       = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                rd_fire = !hold;
                wr_fire = !hold && pending;
                if (rd_fire && last_rd) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                wr_fire = !hold && pending;
                if (wr_fire && last_wr) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) begin
            rd_fire    = 1'b0;
            wr_fire    = 1'b0;
            done_next  = 1'b0;
            state_next = ST_IDLE;
        end
        if (rst) begin
            rd_fire = 1'b0;
            wr_fire = 1'b0;
        end
    end

    // A read issued last cycle stays pending until its write lands; hold freezes both.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_base_q <= '0;
            dst_base_q <= '0;
            len_q      <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            pending    <= 1'b0;
        end else if (load) begin
            src_base_q <= src_base;
            dst_base_q <= dst_base;
            len_q      <= len;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            pending    <= 1'b0;
        end else begin
            if (rd_fire) begin
                rd_cnt <= rd_cnt + LEN_W'(1);
            end
            if (wr_fire) begin
                wr_cnt <= wr_cnt + LEN_W'(1);
            end
            if (rd_fire) begin
                pending <= 1'b1;
            end else if (wr_fire) begin
                pending <= 1'b0;
            end
        end
    end

    assign busy     = (state != ST_IDLE);
    assign src_ce   = rd_fire;
    assign src_oe   = rd_fire;
    assign src_addr = rd_fire ? (src_base_q + rd_cnt[aw-1:0]) : '0;
    assign dst_ce   = wr_fire;
    assign dst_we   = wr_fire;
    assign dst_addr = wr_fire ? (dst_base_q + wr_cnt[aw-1:0]) : '0;
    assign dst_din  = wr_fire ? src_dout : '0;

endmodule

// File: tb/tb_spram_dma.sv
// Directed bench for spram_dma: bench-owned source/destination RAM models, a table of
// copy scenarios with hand-computed timing, plus hand-written reset sequences.
module tb_spram_dma;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort, hold;
    logic [AW-1:0] src_base, dst_base;
    logic [AW:0]   len;
    logic          busy, done, src_ce, src_oe, dst_ce, dst_we;
    logic [AW-1:0] src_addr, dst_addr;
    logic [DW-1:0] src_dout, dst_din;

    always #5 clk = ~clk;

    spram_dma #(.aw(AW), .dw(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done),
        .src_ce(src_ce), .src_oe(src_oe), .src_addr(src_addr), .src_dout(src_dout),
        .dst_ce(dst_ce), .dst_we(dst_we), .dst_addr(dst_addr), .dst_din(dst_din)
    );

    typedef struct {
        logic [7:0] src_base;
        logic [7:0] dst_base;
        int         len;
        int         hold_from;
        int         hold_to;
        int         abort_at;
        int         restart_at;
        bit         abort_with_start;
        int         exp_done;
        int         exp_busy_last;
        int         exp_writes;
        int         exp_reads;
    } vec_t;

    vec_t          vecs[9];
    logic [DW-1:0] src_mem[256];
    logic [DW-1:0] dst_mem[256];
    logic [DW-1:0] exp_mem[256];

    int errors = 0;
    int checks = 0;
    int done_cycle, done_cnt, wr_seen, rd_seen, busy_bad, en_bad, hold_bad;
    logic [39:0] last_outs;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearStats();
        done_cycle = -1;
        done_cnt   = 0;
        wr_seen    = 0;
        rd_seen    = 0;
        busy_bad   = 0;
        en_bad     = 0;
        hold_bad   = 0;
    endtask

    // Samples the DUT at the falling edge, then plays the RAM side of the rising edge.
    task automatic tickCycle(input int c, input bit exp_busy, input bit in_hold);
        logic          cap_rd, cap_wr;
        logic [AW-1:0] cap_src_addr, cap_dst_addr;
        logic [DW-1:0] cap_din;
        @(negedge clk);
        if (done === 1'b1) begin
            if (done_cnt == 0) done_cycle = c;
            done_cnt++;
        end
        if (busy !== exp_busy) busy_bad++;
        if (src_oe !== src_ce || dst_we !== dst_ce) en_bad++;
        if (in_hold && (src_ce || dst_ce || dst_we)) hold_bad++;
        last_outs    = {busy, done, src_ce, src_oe, dst_ce, dst_we, src_addr, dst_addr, dst_din, 2'b00};
        cap_rd       = src_ce;
        cap_wr       = dst_ce && dst_we;
        cap_src_addr = src_addr;
        cap_dst_addr = dst_addr;
        cap_din      = dst_din;
        if (cap_rd) rd_seen++;
        if (cap_wr) wr_seen++;
        @(posedge clk);
        if (cap_wr) dst_mem[cap_dst_addr] = cap_din;
        if (cap_rd) src_dout = src_mem[cap_src_addr];
        #1;
    endtask

    task automatic prepareMem(input logic [7:0] sb, input logic [7:0] db, input int n, input int nw);
        logic [7:0] a8;
        for (int a = 0; a < 256; a++) begin
            src_mem[a] = 8'(a) ^ 8'h5A;
            dst_mem[a] = 8'h00;
            exp_mem[a] = 8'h00;
        end
        for (int i = 0; i < n; i++) begin
            a8 = sb + 8'(i);
            src_mem[a8] = 8'(i) ^ 8'hA5;
        end
        for (int i = 0; i < nw; i++) begin
            a8 = db + 8'(i);
            exp_mem[a8] = 8'(i) ^ 8'hA5;
        end
    endtask

    function automatic int memBad();
        int bad = 0;
        for (int a = 0; a < 256; a++) begin
            if (dst_mem[a] !== exp_mem[a]) bad++;
        end
        return bad;
    endfunction

    // Runs one table row; inputs are scrambled after the start cycle to show they are latched.
    task automatic applyStimulus(input int row, input vec_t v);
        int ncyc;
        prepareMem(v.src_base, v.dst_base, v.len, v.exp_writes);
        clearStats();
        ncyc = v.len + 12;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == v.restart_at);
            if (c == 0) begin
                src_base = v.src_base;
                dst_base = v.dst_base;
                len      = 9'(v.len);
            end else begin
                src_base = v.src_base + 8'h50;
                dst_base = v.dst_base ^ 8'h33;
                len      = 9'd5;
            end
            abort = (c == v.abort_at) || (c == 0 && v.abort_with_start);
            hold  = (c >= v.hold_from) && (c <= v.hold_to);
            tickCycle(c, (c >= 1) && (c <= v.exp_busy_last), hold);
        end
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
        checkOutput($sformatf("row%0d done_cycle", row), done_cycle, v.exp_done);
        checkOutput($sformatf("row%0d done_pulses", row), done_cnt, (v.exp_done >= 0) ? 1 : 0);
        checkOutput($sformatf("row%0d writes", row), wr_seen, v.exp_writes);
        checkOutput($sformatf("row%0d reads", row), rd_seen, v.exp_reads);
        checkOutput($sformatf("row%0d busy_bad_cycles", row), busy_bad, 0);
        checkOutput($sformatf("row%0d enable_pair_bad", row), en_bad, 0);
        checkOutput($sformatf("row%0d access_during_hold", row), hold_bad, 0);
        checkOutput($sformatf("row%0d dst_bad_words", row), memBad(), 0);
    endtask

    initial begin
        vecs[0] = '{8'h10, 8'h40,  16, -1, -2, -1, -1, 1'b0,  18,  17,  16,  16};
        vecs[1] = '{8'hFE, 8'hFD,   4, -1, -2, -1, -1, 1'b0,   6,   5,   4,   4};
        vecs[2] = '{8'h20, 8'h80,   8,  3,  5, -1, -1, 1'b0,  13,  12,   8,   8};
        vecs[3] = '{8'h00, 8'hC0,  32, -1, -2,  6, -1, 1'b0,  -1,   6,   4,   5};
        vecs[4] = '{8'h30, 8'h50,   0, -1, -2, -1, -1, 1'b0,   1,   0,   0,   0};
        vecs[5] = '{8'h33, 8'h99,   1, -1, -2, -1, -1, 1'b0,   3,   2,   1,   1};
        vecs[6] = '{8'h05, 8'h00, 256, -1, -2, -1, -1, 1'b0, 258, 257, 256, 256};
        vecs[7] = '{8'h50, 8'h10,   8, -1, -2, -1,  3, 1'b0,  10,   9,   8,   8};
        vecs[8] = '{8'h60, 8'h20,   4, -1, -2, -1, -1, 1'b1,   6,   5,   4,   4};

        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        hold     = 1'b0;
        src_base = '0;
        dst_base = '0;
        len      = '0;
        src_dout = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset enables", int'({src_ce, src_oe, dst_ce, dst_we}), 0);
        checkOutput("reset src_addr", int'(src_addr), 0);
        checkOutput("reset dst_addr", int'(dst_addr), 0);
        checkOutput("reset dst_din", int'(dst_din), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int r = 0; r < 9; r++) begin
            applyStimulus(r, vecs[r]);
        end

        // Synchronous reset in the middle of a copy behaves like the abort row.
        prepareMem(8'h00, 8'hC0, 32, 4);
        clearStats();
        for (int c = 0; c < 8; c++) begin
            start    = (c == 0);
            src_base = 8'h00;
            dst_base = 8'hC0;
            len      = 9'd32;
            rst      = (c == 6);
            tickCycle(c, (c >= 1) && (c <= 6), 1'b0);
        end
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_mid outputs_after", int'(last_outs != '0), 0);
        checkOutput("rst_mid writes", wr_seen, 4);
        checkOutput("rst_mid done_pulses", done_cnt, 0);
        checkOutput("rst_mid busy_bad_cycles", busy_bad, 0);
        checkOutput("rst_mid dst_bad_words", memBad(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
